// File: rtl/polar_to_cartesian_pkg.sv
// polar_to_cartesian_pkg: shared state encoding, Q0.8 trig table and angle-index limits
package polar_to_cartesian_pkg;
  typedef enum logic [1:0] {IDLE, MULT, FINISH} state_t;
  localparam logic [3:0] N_MAX = 4'd12;
  localparam logic [3:0] N_FOLD = 4'd6;
  localparam logic [6:0][8:0] COEF_TAB = {9'd256, 9'd247, 9'd222, 9'd181, 9'd128, 9'd66, 9'd0};
endpackage

// File: rtl/trig_coef_lut.sv
// trig_coef_lut: folds angle index n into 0..90 degrees and returns sin/cos Q0.8 coefficients
module trig_coef_lut
  import polar_to_cartesian_pkg::*;
#(
  parameter int COEF_W = 9
) (
  input  logic [3:0]        n_i,
  output logic [COEF_W-1:0] sin_coef_o,
  output logic [COEF_W-1:0] cos_coef_o,
  output logic              x_neg_o,
  output logic              illegal_o
);
  logic [2:0] fold;
  // angles past 90 degrees mirror about 90: sin keeps sign, cos flips
  always_comb begin
    illegal_o = n_i > N_MAX;
    x_neg_o = !illegal_o && n_i > N_FOLD;
    fold = x_neg_o ? 3'(N_MAX - n_i) : n_i[2:0];
    sin_coef_o = illegal_o ? '0 : COEF_W'(COEF_TAB[fold]);
    cos_coef_o = illegal_o ? '0 : COEF_W'(COEF_TAB[3'(3'd6 - fold)]);
  end
endmodule

// File: rtl/polar_to_cartesian.sv
// polar_to_cartesian: serial shift-add conversion of (r, 15*n degrees) to signed x/y
module polar_to_cartesian
  import polar_to_cartesian_pkg::*;
#(
  parameter int COEF_W = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] r_theta,
  output logic        busy,
  output logic        done,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        error
);
  localparam int ACC_W = 8 + COEF_W;
  localparam int CNT_W = $clog2(COEF_W + 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0] r_q;
  logic [3:0] n_q;
  logic [ACC_W-1:0] acc_s_q, acc_c_q, r_sh;
  logic [11:0] x_q, y_q, x_d, y_d;
  logic err_q, done_q;
  logic [COEF_W-1:0] sin_coef, cos_coef;
  logic x_neg, illegal;
  logic [7:0] mag_s, mag_c;
  logic last;

  trig_coef_lut #(.COEF_W(COEF_W)) u_lut (
    .n_i       (n_q),
    .sin_coef_o(sin_coef),
    .cos_coef_o(cos_coef),
    .x_neg_o   (x_neg),
    .illegal_o (illegal)
  );

  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;

  // next state: one accept cycle, COEF_W multiply cycles, one finish cycle
  always_comb begin
    last = cnt_q == CNT_W'(COEF_W - 1);
    state_d = state_q == IDLE ? (start ? MULT : IDLE) :
              state_q == MULT ? (last ? FINISH : MULT) : IDLE;
  end

  // magnitudes are product >> 8; the largest product 255*256 still fits in 8 bits after the shift
  always_comb begin
    r_sh = ACC_W'(r_q) << cnt_q;
    mag_s = 8'(acc_s_q >> 8);
    mag_c = 8'(acc_c_q >> 8);
    x_d = illegal ? '0 : x_neg ? -{4'd0, mag_c} : {4'd0, mag_c};
    y_d = illegal ? '0 : {4'd0, mag_s};
  end

  // capture request, accumulate one coefficient bit per cycle, then register results
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      r_q <= '0;
      n_q <= '0;
      acc_s_q <= '0;
      acc_c_q <= '0;
      x_q <= '0;
      y_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= state_q == FINISH;
      if (state_q == IDLE && start) begin
        r_q <= r_theta[7:0];
        n_q <= r_theta[11:8];
        cnt_q <= '0;
        acc_s_q <= '0;
        acc_c_q <= '0;
      end else if (state_q == MULT) begin
        cnt_q <= cnt_q + 1'b1;
        acc_s_q <= acc_s_q + (sin_coef[cnt_q] ? r_sh : '0);
        acc_c_q <= acc_c_q + (cos_coef[cnt_q] ? r_sh : '0);
      end
      if (state_q == FINISH) begin
        x_q <= x_d;
        y_q <= y_d;
        err_q <= illegal;
      end
    end

  // outputs
  always_comb begin
    busy = state_q != IDLE;
    done = done_q;
    x = x_q;
    y = y_q;
    error = err_q;
  end
endmodule

// File: tb/tb_polar_to_cartesian.sv
// tb_polar_to_cartesian: directed vectors with a queue scoreboard and done-driven monitor
module tb_polar_to_cartesian;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [11:0] r_theta = '0;
  logic busy, done, error;
  logic [11:0] x, y;
  int checks = 0, errors = 0, cyc = 0;

  typedef struct {logic [11:0] x; logic [11:0] y; logic e; int acc;} exp_t;
  exp_t exp_q[$];

  polar_to_cartesian dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .r_theta(r_theta),
    .busy   (busy),
    .done   (done),
    .x      (x),
    .y      (y),
    .error  (error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clock)
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: x=%0h y=%0h error=%0b", x, y, error);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("x", 32'(x), 32'(e.x));
        chk("y", 32'(y), 32'(e.y));
        chk("error", 32'(error), 32'(e.e));
        chk("latency", 32'(cyc - e.acc), 32'd10);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end

  task automatic issue(input logic [7:0] r, input logic [3:0] n, input logic [11:0] ex, input logic [11:0] ey, input logic ee);
    exp_t e;
    start = 1'b1;
    r_theta = {n, r};
    e.x = ex; e.y = ey; e.e = ee; e.acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40 && !done; k++) @(negedge clock);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: done=%0b expected 1", done);
    end
  endtask

  task automatic run(input logic [7:0] r, input logic [3:0] n, input logic [11:0] ex, input logic [11:0] ey, input logic ee);
    @(negedge clock);
    issue(r, n, ex, ey, ee);
    wait_done();
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    run(8'd200, 4'd2, 12'd173, 12'd100, 1'b0);
    run(8'd200, 4'd8, 12'hF9C, 12'd173, 1'b0);
    run(8'd200, 4'd7, 12'hFCD, 12'd192, 1'b0);
    @(negedge clock);
    issue(8'd200, 4'd6, 12'd0, 12'd200, 1'b0);
    wait_done();
    issue(8'd200, 4'd12, 12'hF38, 12'd0, 1'b0);
    repeat (3) @(negedge clock);
    start = 1'b1;
    r_theta = {4'd13, 8'd9};
    @(negedge clock);
    start = 1'b0;
    wait_done();
    chk("hold_x_pre", 32'(x), 32'hF38);
    repeat (3) @(negedge clock);
    chk("hold_x", 32'(x), 32'hF38);
    chk("hold_y", 32'(y), 32'd0);
    run(8'd255, 4'd3, 12'd180, 12'd180, 1'b0);
    run(8'd255, 4'd0, 12'd255, 12'd0, 1'b0);
    run(8'd50, 4'd13, 12'd0, 12'd0, 1'b1);
    run(8'd100, 4'd4, 12'd50, 12'd86, 1'b0);
    @(negedge clock);
    issue(8'd10, 4'd1, 12'd0, 12'd0, 1'b0);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_x", 32'(x), 32'd0);
    chk("mid_rst_y", 32'(y), 32'd0);
    chk("mid_rst_error", 32'(error), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (15) @(negedge clock);
    chk("post_rst_busy", 32'(busy), 32'd0);
    run(8'd0, 4'd5, 12'd0, 12'd0, 1'b0);
    run(8'd120, 4'd10, 12'hF98, 12'd60, 1'b0);
    repeat (15) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
